// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, and buffers returned words in a 2-entry FIFO for decode.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, except imem_req_valid which
    // deliberately looks at id_ready so a full FIFO can still sustain 1 IPC.
    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_tag_pc;
    logic        r_out;
    logic [1:0]  r_cnt;
    logic [31:0] r_instr0, r_pc0, r_instr1, r_pc1;

    logic        w_pop, w_rsp, w_push, w_req_en, w_accept, w_rsp_ok;
    logic [2:0]  w_occ;

    assign w_pop    = id_valid & id_ready;
    // A response with nothing outstanding (e.g. left over across reset) is ignored.
    assign w_rsp    = imem_rsp_valid & r_out;
    assign w_push   = w_rsp & (r_state == ST_RUN) & !redirect_valid;
    assign w_occ    = {1'b0, r_cnt} + {2'b00, r_out} - {2'b00, w_pop};
    assign w_rsp_ok = (r_state == ST_DRAIN) ? imem_rsp_valid : (!r_out | imem_rsp_valid);
    assign w_req_en = rst_n & !redirect_valid & w_rsp_ok & (w_occ < 3'd2);
    assign w_accept = w_req_en & imem_req_ready;

    assign imem_req_valid = w_req_en;
    assign imem_req_addr  = r_pc;
    assign id_valid       = (r_cnt != 2'd0);
    assign id_instr       = id_valid ? r_instr0 : NOP_INSTR;
    assign id_pc          = id_valid ? r_pc0 : 32'h0;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN means the one outstanding response belongs to a squashed path.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (r_out & !imem_rsp_valid) ? ST_DRAIN : ST_RUN;
        end else if (w_rsp) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC & ~32'h3;
            r_tag_pc <= 32'h0;
            r_out    <= 1'b0;
        end else if (redirect_valid) begin
            r_pc  <= redirect_pc & ~32'h3;
            r_out <= r_out & !imem_rsp_valid;
        end else if (w_accept) begin
            r_pc     <= r_pc + 32'd4;
            r_tag_pc <= r_pc;
            r_out    <= 1'b1;
        end else if (w_rsp) begin
            r_out <= 1'b0;
        end
    end

    // Entry 0 is always the head, so the decode-facing outputs need no muxing by pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_instr0 <= 32'h0;
            r_pc0    <= 32'h0;
            r_instr1 <= 32'h0;
            r_pc1    <= 32'h0;
        end else if (redirect_valid) begin
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_instr0 <= imem_rsp_data;
                        r_pc0    <= r_tag_pc;
                    end else begin
                        r_instr1 <= imem_rsp_data;
                        r_pc1    <= r_tag_pc;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_instr0 <= r_instr1;
                    r_pc0    <= r_pc1;
                    r_cnt    <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_instr0 <= imem_rsp_data;
                        r_pc0    <= r_tag_pc;
                    end else begin
                        r_instr0 <= r_instr1;
                        r_pc0    <= r_pc1;
                        r_instr1 <= imem_rsp_data;
                        r_pc1    <= r_tag_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_cnt == 2'd2));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a latency-configurable instruction memory model feeds the
// DUT, and every accepted fetch is queued as the {pc,instr} decode should see.
module tb_if_stage;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;
    logic        o_dbg_state;

    if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc = RST_PC;

    int          lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_left = 0;
    logic [31:0] mem_addr = 32'h0;

    logic        s_rsp, s_id_valid, s_req_valid, s_state, s_pop, s_acc;
    logic [31:0] s_addr;
    logic [63:0] s_head, head0;
    int          pops, accs;
    logic        found;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample and score.
    task automatic cycle(input logic rdy, input logic rr, input logic redir, input logic [31:0] rpc);
        logic [63:0] want;
        @(negedge clk);
        id_ready       = rdy;
        imem_req_ready = rr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_addr ^ KEY;
                mem_busy       = 1'b0;
            end
        end
        #1;
        s_rsp       = imem_rsp_valid;
        s_id_valid  = id_valid;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_state     = o_dbg_state;
        s_pop       = id_valid & id_ready;
        s_acc       = imem_req_valid & imem_req_ready;
        s_head      = {id_pc, id_instr};
        if (s_pop) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("pop", s_head, want);
        end
        if (redir) begin
            check("req_during_redirect", {63'b0, imem_req_valid}, 64'd0);
            exp_q.delete();
            exp_pc = rpc & ~32'h3;
        end
        if (s_acc) begin
            check("one_outstanding", {63'b0, mem_busy}, 64'd0);
            check("req_addr", {32'b0, s_addr}, {32'b0, exp_pc});
            exp_q.push_back({s_addr, s_addr ^ KEY});
            mem_busy = 1'b1;
            mem_left = lat;
            mem_addr = s_addr;
            exp_pc   = exp_pc + 32'd4;
        end
    endtask

    initial begin
        id_ready = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        check("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("rst_req_addr", {32'b0, imem_req_addr}, {32'b0, RST_PC});
        check("rst_id", {31'b0, id_valid, id_instr}, {32'b0, NOP});
        check("rst_id_pc", {32'b0, id_pc}, 64'd0);
        check("rst_state", {63'b0, o_dbg_state}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Stream: request in cycle 1, decode sees it in cycle 3, then 1 IPC
        cycle(1, 1, 0, 0);
        check("c1_req", {s_req_valid, s_addr}, {1'b1, RST_PC});
        check("c1_id_valid", {63'b0, s_id_valid}, 64'd0);
        cycle(1, 1, 0, 0);
        check("c2_id_valid", {63'b0, s_id_valid}, 64'd0);
        cycle(1, 1, 0, 0);
        check("c3_id_valid", {63'b0, s_id_valid}, 64'd1);
        pops = 0; accs = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 1, 0, 0);
            pops += int'(s_pop);
            accs += int'(s_acc);
        end
        check("stream_pops", 64'(pops), 64'd16);
        check("stream_reqs", 64'(accs), 64'd16);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 0);
            if (i == 0) head0 = s_head;
        end
        check("bp_id_valid", {63'b0, s_id_valid}, 64'd1);
        check("bp_req_valid", {63'b0, s_req_valid}, 64'd0);
        check("bp_head_stable", s_head, head0);
        repeat (5) cycle(1, 1, 0, 0);

        // Redirect with a full FIFO and nothing outstanding
        repeat (3) cycle(0, 1, 0, 0);
        check("ri_full_req_valid", {63'b0, s_req_valid}, 64'd0);
        cycle(0, 1, 1, 32'h0000_2003);
        cycle(1, 1, 0, 0);
        check("ri_id_valid", {63'b0, s_id_valid}, 64'd0);
        check("ri_req", {s_acc, s_addr}, {1'b1, 32'h0000_2000});
        repeat (4) cycle(1, 1, 0, 0);

        // Stale drop with a 3-cycle memory
        lat = 3;
        repeat (4) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'h0000_0010);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 0);
            if (s_acc && s_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        check("sd_req_10", {63'b0, found}, 64'd1);
        cycle(1, 1, 1, 32'h0000_0400);
        cycle(1, 1, 0, 0);
        check("sd_drain_state", {63'b0, s_state}, 64'd1);
        check("sd_no_req", {63'b0, s_req_valid}, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0);
            if (s_rsp) begin
                found = 1'b1;
                break;
            end
        end
        check("sd_rsp_seen", {63'b0, found}, 64'd1);
        check("sd_req_400", {31'b0, s_acc, s_addr}, {31'b0, 1'b1, 32'h0000_0400});
        repeat (8) cycle(1, 1, 0, 0);

        // Wrap and redirect coincident with response and pop
        lat = 1;
        repeat (6) cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        check("wc_rsp", {63'b0, s_rsp}, 64'd1);
        check("wc_pop", {63'b0, s_pop}, 64'd1);
        cycle(1, 1, 0, 0);
        check("wc_state", {63'b0, s_state}, 64'd0);
        check("wc_empty", {63'b0, s_id_valid}, 64'd0);
        check("wc_req_top", {31'b0, s_acc, s_addr}, {31'b0, 1'b1, 32'hFFFF_FFFC});
        cycle(1, 1, 0, 0);
        check("wc_wrap", {31'b0, s_acc, s_addr}, {31'b0, 1'b1, 32'h0});
        repeat (3) cycle(1, 1, 0, 0);

        // Random traffic: stalls, memory backpressure, latency, redirects
        for (int i = 0; i < 80; i++) begin
            lat = $urandom_range(1, 3);
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0), $urandom);
        end
        lat = 1;
        repeat (6) cycle(1, 1, 0, 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("ar_req_valid", {63'b0, imem_req_valid}, 64'd0);
        check("ar_req_addr", {32'b0, imem_req_addr}, {32'b0, RST_PC});
        check("ar_id", {31'b0, id_valid, id_instr}, {32'b0, NOP});
        check("ar_id_pc", {32'b0, id_pc}, 64'd0);
        mem_busy = 1'b0;
        exp_q.delete();
        exp_pc = RST_PC;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cycle(1, 1, 0, 0);
        check("ar_restart", {31'b0, s_acc, s_addr}, {31'b0, 1'b1, RST_PC});
        repeat (6) cycle(1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
